// File: rtl/status_ctrl_pkg.sv
// Shared types and constants for the NZCV status write scheduler.
package status_ctrl_pkg;

  localparam int unsigned FLAG_W_DEF = 4;
  localparam int unsigned PEND_W     = 2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StWrite
  } msr_state_e;

endpackage

// File: rtl/status_write_scheduler_if.sv
// Pipeline <-> status write scheduler signal bundle.
// Forward ports exist only when FLAG_FORWARD_EN is defined.
interface status_write_scheduler_if
  import status_ctrl_pkg::*;
#(
  parameter int unsigned FLAG_W = FLAG_W_DEF,
  parameter int unsigned PW     = PEND_W
);
  logic              i_Id_Issue;
  logic              i_Id_Cond;
  logic              i_Ex_Valid;
  logic              i_Ex_Set_Flags;
  logic [FLAG_W-1:0] i_Ex_Flags;
  logic              i_Flush;
  logic              i_Msr_Req;
  logic [FLAG_W-1:0] i_Msr_Flags;
  logic              o_Msr_Ack;
  logic              o_Status_We;
  logic [FLAG_W-1:0] o_Status_Data;
  logic              o_Stall;
  logic              o_Issue_Hold;
  logic [PW-1:0]     o_Pending;
`ifdef FLAG_FORWARD_EN
  logic              o_Fwd_Valid;
  logic [FLAG_W-1:0] o_Fwd_Flags;
`endif

  modport master (
    output i_Id_Issue, i_Id_Cond, i_Ex_Valid, i_Ex_Set_Flags, i_Ex_Flags, i_Flush,
           i_Msr_Req, i_Msr_Flags,
    input  o_Msr_Ack, o_Status_We, o_Status_Data, o_Stall, o_Issue_Hold, o_Pending
`ifdef FLAG_FORWARD_EN
    , input o_Fwd_Valid, o_Fwd_Flags
`endif
  );

  modport slave (
    input  i_Id_Issue, i_Id_Cond, i_Ex_Valid, i_Ex_Set_Flags, i_Ex_Flags, i_Flush,
           i_Msr_Req, i_Msr_Flags,
    output o_Msr_Ack, o_Status_We, o_Status_Data, o_Stall, o_Issue_Hold, o_Pending
`ifdef FLAG_FORWARD_EN
    , output o_Fwd_Valid, o_Fwd_Flags
`endif
  );

endinterface

// File: rtl/flag_inflight_counter.sv
// Saturating up/down counter of in-flight flag-setters with flush clear and full flag.
module flag_inflight_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  localparam logic [W-1:0] MaxCnt = W'(MAX);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec && count_q != MaxCnt) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MaxCnt);

endmodule

// File: rtl/status_write_scheduler.sv
// Sequences NZCV status writes from EX and an MSR port; tracks flag hazards for decode.
// Optional flag forwarding on the EX write cycle is enabled by defining FLAG_FORWARD_EN.
module status_write_scheduler
  import status_ctrl_pkg::*;
#(
  parameter int unsigned FLAG_W       = FLAG_W_DEF,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned MSR_MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  status_write_scheduler_if.slave bus
);

  localparam int unsigned   WaitW   = $clog2(MSR_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitSat = WaitW'(MSR_MAX_WAIT - 1);

  msr_state_e        state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              we_q, we_d;
  logic              src_ex_q, src_ex_d;
  logic [FLAG_W-1:0] data_q, data_d;

  logic [PEND_W-1:0] pending;
  logic              full;
  logic              ex_wr;
  logic              enter_write;
  logic              issue_hold;
  logic              issue_ok;
  logic              retire;
  logic              hazard;

  assign ex_wr    = bus.i_Ex_Valid & bus.i_Ex_Set_Flags & ~bus.i_Flush;
  assign retire   = we_q & src_ex_q;
  assign issue_ok = bus.i_Id_Issue & ~issue_hold;

  assign issue_hold = full
                    | (state_q == StWrite)
                    | ((state_q == StWait) && (wait_q >= WaitSat));

  flag_inflight_counter #(
    .MAX (MAX_INFLIGHT),
    .W   (PEND_W)
  ) u_inflight (
    .clk   (clk),
    .reset (reset),
    .clear (bus.i_Flush),
    .inc   (issue_ok),
    .dec   (retire),
    .count (pending),
    .full  (full)
  );

  // MSR write only starts with nothing in flight, so it can never collide with an EX write.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    enter_write = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_Msr_Req) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        if (wait_q != WaitSat) begin
          wait_d = wait_q + WaitW'(1);
        end
        if (pending == '0 && !bus.i_Id_Issue && !ex_wr) begin
          state_d     = StWrite;
          enter_write = 1'b1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d     = ex_wr | enter_write;
    src_ex_d = ex_wr;
    data_d   = data_q;
    if (ex_wr) begin
      data_d = bus.i_Ex_Flags;
    end else if (enter_write) begin
      data_d = bus.i_Msr_Flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      we_q     <= 1'b0;
      src_ex_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      src_ex_q <= src_ex_d;
      data_q   <= data_d;
    end
  end

  assign hazard = (pending != '0) | (state_q == StWrite);

`ifdef FLAG_FORWARD_EN
  logic fwd;
  // The lone in-flight setter is on the write port now, so its flags can bypass the register.
  assign fwd             = (pending == PEND_W'(1)) & retire;
  assign bus.o_Fwd_Valid = fwd;
  assign bus.o_Fwd_Flags = data_q;
  assign bus.o_Stall     = bus.i_Id_Cond & hazard & ~fwd;
`else
  assign bus.o_Stall     = bus.i_Id_Cond & hazard;
`endif

  assign bus.o_Msr_Ack     = (state_q == StWrite);
  assign bus.o_Status_We   = we_q;
  assign bus.o_Status_Data = data_q;
  assign bus.o_Issue_Hold  = issue_hold;
  assign bus.o_Pending     = pending;

  a_no_issue_when_full : assert property (@(posedge clk) disable iff (reset)
    !(bus.i_Id_Issue && full));

endmodule

// File: tb/tb_status_write_scheduler.sv
// Directed bench for status_write_scheduler: reset, EX/MSR writes, flush, MSR hold-off.
module tb_status_write_scheduler;
  import status_ctrl_pkg::*;

`ifdef FLAG_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  status_write_scheduler_if #(.FLAG_W(4), .PW(2)) bus ();

  status_write_scheduler #(
    .FLAG_W       (4),
    .MAX_INFLIGHT (3),
    .MSR_MAX_WAIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       issue, cond, exv, exs;
    bit [3:0] exf;
    bit       flush, req;
    bit [3:0] msrf;
    bit       we;
    bit [3:0] data;
    bit       ack, stall, hold;
    bit [1:0] pend;
    bit       fwd;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t v(input bit issue, input bit cond, input bit exv, input bit exs,
                             input bit [3:0] exf, input bit flush, input bit req,
                             input bit [3:0] msrf, input bit we, input bit [3:0] data,
                             input bit ack, input bit stall, input bit hold,
                             input bit [1:0] pend, input bit fwd);
    vec_t r;
    r.issue = issue; r.cond = cond; r.exv = exv; r.exs = exs; r.exf = exf;
    r.flush = flush; r.req = req; r.msrf = msrf;
    r.we = we; r.data = data; r.ack = ack; r.stall = stall; r.hold = hold;
    r.pend = pend; r.fwd = fwd;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_Id_Issue = 1'b0; bus.i_Id_Cond = 1'b0; bus.i_Ex_Valid = 1'b0;
    bus.i_Ex_Set_Flags = 1'b0; bus.i_Ex_Flags = 4'h0; bus.i_Flush = 1'b0;
    bus.i_Msr_Req = 1'b0; bus.i_Msr_Flags = 4'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    8'(bus.o_Status_We),   8'h0);
    check({tag, "_data"},  8'(bus.o_Status_Data), 8'h0);
    check({tag, "_ack"},   8'(bus.o_Msr_Ack),     8'h0);
    check({tag, "_stall"}, 8'(bus.o_Stall),       8'h0);
    check({tag, "_hold"},  8'(bus.o_Issue_Hold),  8'h0);
    check({tag, "_pend"},  8'(bus.o_Pending),     8'h0);
  endtask

  logic [12:0] t4_hold;
  logic [12:0] t4_we;
  logic [1:0]  t4_pend [13];

  initial begin
    // EX write path, MSR write, counter corners, flush; S marks the forwarded-stall case.
    vecs[0]  = v(H,H,L,L,4'h0,L,L,4'h0, L,4'h0,L,L,L,2'd0,L);
    vecs[1]  = v(L,H,L,L,4'h0,L,L,4'h0, L,4'h0,L,H,L,2'd1,L);
    vecs[2]  = v(L,H,H,H,4'hC,L,L,4'h0, L,4'h0,L,H,L,2'd1,L);
    vecs[3]  = v(L,H,L,L,4'h0,L,L,4'h0, H,4'hC,L,Fwd ? L : H,L,2'd1,H);
    vecs[4]  = v(L,H,L,L,4'h0,L,L,4'h0, L,4'hC,L,L,L,2'd0,L);
    vecs[5]  = v(L,L,L,L,4'h0,L,H,4'h5, L,4'hC,L,L,L,2'd0,L);
    vecs[6]  = v(L,L,L,L,4'h0,L,H,4'h5, L,4'hC,L,L,L,2'd0,L);
    vecs[7]  = v(L,H,L,L,4'h0,L,H,4'h5, H,4'h5,H,H,H,2'd0,L);
    vecs[8]  = v(L,H,L,L,4'h0,L,L,4'h0, L,4'h5,L,L,L,2'd0,L);
    vecs[9]  = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h5,L,L,L,2'd0,L);
    vecs[10] = v(L,H,H,H,4'h3,L,L,4'h0, L,4'h5,L,H,L,2'd1,L);
    vecs[11] = v(L,H,L,L,4'h0,L,L,4'h0, H,4'h3,L,Fwd ? L : H,L,2'd1,H);
    vecs[12] = v(L,L,L,L,4'h0,L,L,4'h0, L,4'h3,L,L,L,2'd0,L);
    vecs[13] = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h3,L,L,L,2'd0,L);
    vecs[14] = v(L,L,H,L,4'hF,L,L,4'h0, L,4'h3,L,L,L,2'd1,L);
    vecs[15] = v(L,L,H,H,4'h9,L,L,4'h0, L,4'h3,L,L,L,2'd1,L);
    vecs[16] = v(H,L,L,L,4'h0,L,L,4'h0, H,4'h9,L,L,L,2'd1,H);
    vecs[17] = v(L,L,H,H,4'h6,L,L,4'h0, L,4'h9,L,L,L,2'd1,L);
    vecs[18] = v(L,L,L,L,4'h0,L,L,4'h0, H,4'h6,L,L,L,2'd1,H);
    vecs[19] = v(L,L,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd0,L);
    vecs[20] = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd0,L);
    vecs[21] = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd1,L);
    vecs[22] = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd2,L);
    vecs[23] = v(L,H,H,H,4'hF,H,L,4'h0, L,4'h6,L,H,H,2'd3,L);
    vecs[24] = v(L,H,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd0,L);
    vecs[25] = v(H,L,L,L,4'h0,L,L,4'h0, L,4'h6,L,L,L,2'd0,L);
    vecs[26] = v(L,L,H,H,4'hA,L,L,4'h0, L,4'h6,L,L,L,2'd1,L);
    vecs[27] = v(L,L,L,L,4'h0,H,L,4'h0, H,4'hA,L,L,L,2'd1,H);
    vecs[28] = v(L,L,L,L,4'h0,L,L,4'h0, L,4'hA,L,L,L,2'd0,L);
    vecs[29] = v(L,L,H,H,4'h1,L,L,4'h0, L,4'hA,L,L,L,2'd0,L);
    vecs[30] = v(L,L,L,L,4'h0,L,L,4'h0, H,4'h1,L,L,L,2'd0,L);
    vecs[31] = v(L,L,L,L,4'h0,L,L,4'h0, L,4'h1,L,L,L,2'd0,L);

    t4_hold = 13'b0_1111_0000_0000;
    t4_we   = 13'b0_1011_1111_1100;
    t4_pend = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

    idle_inputs();
    reset = 1'b1;
    next_cycle();
    check_all_zero("reset");
    reset = 1'b0;

    // Reset asserted with an MSR waiting and an EX write on the outputs.
    bus.i_Id_Issue = 1'b1; bus.i_Msr_Req = 1'b1; bus.i_Msr_Flags = 4'hF;
    next_cycle();
    bus.i_Id_Issue = 1'b0; bus.i_Ex_Valid = 1'b1; bus.i_Ex_Set_Flags = 1'b1;
    bus.i_Ex_Flags = 4'hA;
    next_cycle();
    check("pre_reset_we", 8'(bus.o_Status_We), 8'h1);
    idle_inputs();
    bus.i_Id_Cond = 1'b1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("post_reset%0d_ack", k), 8'(bus.o_Msr_Ack), 8'h0);
      check($sformatf("post_reset%0d_we", k), 8'(bus.o_Status_We), 8'h0);
      next_cycle();
    end
    idle_inputs();

    for (int i = 0; i < 32; i++) begin
      bus.i_Id_Issue     = vecs[i].issue;
      bus.i_Id_Cond      = vecs[i].cond;
      bus.i_Ex_Valid     = vecs[i].exv;
      bus.i_Ex_Set_Flags = vecs[i].exs;
      bus.i_Ex_Flags     = vecs[i].exf;
      bus.i_Flush        = vecs[i].flush;
      bus.i_Msr_Req      = vecs[i].req;
      bus.i_Msr_Flags    = vecs[i].msrf;
      #1;
      check($sformatf("r%0d_we", i),    8'(bus.o_Status_We),   8'(vecs[i].we));
      check($sformatf("r%0d_data", i),  8'(bus.o_Status_Data), 8'(vecs[i].data));
      check($sformatf("r%0d_ack", i),   8'(bus.o_Msr_Ack),     8'(vecs[i].ack));
      check($sformatf("r%0d_stall", i), 8'(bus.o_Stall),       8'(vecs[i].stall));
      check($sformatf("r%0d_hold", i),  8'(bus.o_Issue_Hold),  8'(vecs[i].hold));
      check($sformatf("r%0d_pend", i),  8'(bus.o_Pending),     8'(vecs[i].pend));
`ifdef FLAG_FORWARD_EN
      check($sformatf("r%0d_fwd", i), 8'(bus.o_Fwd_Valid), 8'(vecs[i].fwd));
      if (vecs[i].fwd)
        check($sformatf("r%0d_fwd_flags", i), 8'(bus.o_Fwd_Flags), 8'(vecs[i].data));
`endif
      next_cycle();
    end
    idle_inputs();

    // MSR starved by back-to-back flag-setters until the wait limit holds off issue.
    for (int c = 0; c < 13; c++) begin
      bus.i_Id_Issue     = (c <= 7);
      bus.i_Ex_Valid     = (c >= 1 && c <= 8);
      bus.i_Ex_Set_Flags = (c >= 1 && c <= 8);
      bus.i_Ex_Flags     = 4'(c);
      bus.i_Msr_Req      = (c <= 11);
      bus.i_Msr_Flags    = 4'h8;
      #1;
      check($sformatf("t4_c%0d_hold", c), 8'(bus.o_Issue_Hold), 8'(t4_hold[c]));
      check($sformatf("t4_c%0d_pend", c), 8'(bus.o_Pending),    8'(t4_pend[c]));
      check($sformatf("t4_c%0d_we", c),   8'(bus.o_Status_We),  8'(t4_we[c]));
      check($sformatf("t4_c%0d_ack", c),  8'(bus.o_Msr_Ack),    8'(c == 11));
      if (c == 5)  check("t4_c5_data",  8'(bus.o_Status_Data), 8'h4);
      if (c == 11) check("t4_c11_data", 8'(bus.o_Status_Data), 8'h8);
      if (c == 12) check("t4_c12_data", 8'(bus.o_Status_Data), 8'h8);
      next_cycle();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
